// File: rtl/lsu_resp_unit_if.sv
// lsu_resp_unit_if: request, data-bus and result signals of the LS-pipeline responder.
package lsu_pkg;
  typedef struct packed {
    logic        rf_we;
    logic [31:0] pc;
    logic [1:0]  data_type;
    logic [3:0]  amo_flag;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
  } lsu_req_info_t;
  typedef struct packed {
    logic [31:0] wdata;
    logic        err;
    logic [4:0]  rd;
    logic [31:0] pc;
    logic        rf_we;
  } pl_out_t;
endpackage

interface lsu_resp_unit_if;
  import lsu_pkg::*;
  logic          flush_i;
  logic          lsu_req_valid_i;
  lsu_req_info_t lsu_req_i;
  logic          lsu_rdy_o;
  logic          data_req_o;
  logic          data_we_o;
  logic [3:0]    data_be_o;
  logic [31:0]   data_addr_o;
  logic [31:0]   data_wdata_o;
  logic          data_lock_o;
  logic          data_gnt_i;
  logic          data_rvalid_i;
  logic [31:0]   data_rdata_i;
  logic          data_err_i;
  logic          lspl_valid_o;
  pl_out_t       lspl_output_o;
  modport slave (
    input  flush_i, lsu_req_valid_i, lsu_req_i, data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
    output lsu_rdy_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, data_lock_o,
           lspl_valid_o, lspl_output_o
  );
  modport master (
    output flush_i, lsu_req_valid_i, lsu_req_i, data_gnt_i, data_rvalid_i, data_rdata_i, data_err_i,
    input  lsu_rdy_o, data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, data_lock_o,
           lspl_valid_o, lspl_output_o
  );
endinterface

// File: rtl/lsu_resp_unit.sv
// lsu_resp_unit: runs one LS request as a single data-bus transaction and owns the AMO bus lock.
module lsu_resp_unit
  import lsu_pkg::*;
(
  input logic            clk_i,
  input logic            rst_i,
  lsu_resp_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, RESP, ERR, DRAIN} state_e;
  state_e      state_q, state_d;
  logic        req_q, we_q, lock_q, err_q, rf_we_q;
  logic [3:0]  be_q, flag_q;
  logic [31:0] addr_q, wdata_q, pc_q, rdata_q;
  logic [4:0]  rd_q;
  logic [1:0]  type_q, off_q;
  logic        accept, imm_err, legal_flag, misal, amo_rd, amo_wr;
  logic [3:0]  be_d;
  logic [31:0] wdata_d, ld_res;
  lsu_req_info_t r;
  assign r          = bus.lsu_req_i;
  assign accept     = bus.lsu_req_valid_i & (state_q == IDLE) & ~bus.flush_i;
  assign legal_flag = r.amo_flag == 4'b0000 || r.amo_flag == 4'b0100 || r.amo_flag == 4'b1000;
  assign misal      = (r.data_type == 2'b00 && r.addr[1:0] != 2'b00) || (r.data_type == 2'b01 && r.addr[0]);
  assign imm_err    = ~legal_flag | misal | (r.data_type == 2'b11) | (r.amo_flag != 4'b0000 && r.data_type != 2'b00);
  assign be_d       = r.data_type == 2'b00 ? 4'hF :
                      r.data_type == 2'b01 ? 4'b0011 << r.addr[1:0] : 4'b0001 << r.addr[1:0];
  assign wdata_d    = r.data_type == 2'b00 ? r.wdata :
                      r.data_type == 2'b01 ? {2{r.wdata[15:0]}} : {4{r.wdata[7:0]}};
  assign amo_rd     = flag_q == 4'b0100;
  assign amo_wr     = flag_q == 4'b1000;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = accept ? (imm_err ? ERR : REQ) : IDLE;
      REQ:     state_d = bus.data_gnt_i ? (bus.flush_i ? DRAIN : WAIT) : (bus.flush_i ? IDLE : REQ);
      WAIT:    state_d = bus.data_rvalid_i ? (bus.flush_i ? IDLE : RESP) : (bus.flush_i ? DRAIN : WAIT);
      DRAIN:   state_d = bus.data_rvalid_i ? IDLE : DRAIN;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      be_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      lock_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      rf_we_q <= 1'b0;
      pc_q    <= '0;
      rd_q    <= '0;
      type_q  <= '0;
      flag_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        rf_we_q <= r.rf_we;
        pc_q    <= r.pc;
        rd_q    <= r.rd;
        type_q  <= r.data_type;
        flag_q  <= r.amo_flag;
        off_q   <= r.addr[1:0];
        err_q   <= imm_err;
        rdata_q <= '0;
      end
      if (accept && !imm_err) begin
        req_q   <= 1'b1;
        we_q    <= r.amo_flag == 4'b1000 || (r.amo_flag == 4'b0000 && !r.rf_we);
        be_q    <= be_d;
        addr_q  <= {r.addr[31:2], 2'b00};
        wdata_q <= wdata_d;
      end else if (state_q == REQ && (bus.data_gnt_i || bus.flush_i)) begin
        req_q <= 1'b0;
      end
      if (state_q == WAIT && bus.data_rvalid_i) begin
        rdata_q <= bus.data_rdata_i;
        err_q   <= bus.data_err_i;
      end
      // Lock spans the AMO read/write pair; a failed AMO read abandons it.
      if (bus.flush_i)
        lock_q <= 1'b0;
      else if (accept && !imm_err && r.amo_flag == 4'b0100)
        lock_q <= 1'b1;
      else if (state_q == RESP && (amo_wr || (amo_rd && err_q)))
        lock_q <= 1'b0;
    end
  end
  always_comb begin
    ld_res = type_q == 2'b00 ? rdata_q :
             type_q == 2'b01 ? {{16{rdata_q[{off_q[1], 4'b0000} + 15]}}, rdata_q[{off_q[1], 4'b0000} +: 16]} :
                               {{24{rdata_q[{off_q, 3'b000} + 7]}}, rdata_q[{off_q, 3'b000} +: 8]};
    bus.lsu_rdy_o           = state_q == IDLE;
    bus.data_req_o          = req_q;
    bus.data_we_o           = we_q;
    bus.data_be_o           = be_q;
    bus.data_addr_o         = addr_q;
    bus.data_wdata_o        = wdata_q;
    bus.data_lock_o         = lock_q;
    bus.lspl_valid_o        = (state_q == RESP || state_q == ERR) && !bus.flush_i;
    bus.lspl_output_o.wdata = (state_q == RESP && !we_q) ? ld_res : 32'h0;
    bus.lspl_output_o.err   = err_q;
    bus.lspl_output_o.rd    = rd_q;
    bus.lspl_output_o.pc    = pc_q;
    bus.lspl_output_o.rf_we = rf_we_q;
  end
endmodule

// File: doc/lsu_resp_unit.md
# lsu_resp_unit

Load/store responder at the far end of the LS-pipeline request interface. It accepts one `lsu_req_info_t` request at a time from the complex unit or the issuer and runs it as a single data-bus transaction with req/gnt/rvalid handshakes. It returns a one-cycle `pl_out_t` result pulse to the requester. It owns the bus lock that makes an AMO read/write pair atomic, and it drains or cancels in-flight work on flush.

## Interface
- No parameters.
- `clk_i` in 1: clock.
- `rst_i` in 1: reset, asynchronous, active-high.
- `flush_i` in 1: pipeline flush.
- `lsu_req_valid_i` in 1: request valid.
- `lsu_req_i` in `lsu_req_info_t`: request. Fields used: rf_we, pc, data_type[1:0], amo_flag[3:0], addr[31:0], wdata[31:0], rd.
- `lsu_rdy_o` out 1: ready to accept.
- `data_req_o` out 1: bus request.
- `data_we_o` out 1: write.
- `data_be_o` out 4: byte enables.
- `data_addr_o` out 32: word-aligned address.
- `data_wdata_o` out 32: lane-replicated write data.
- `data_lock_o` out 1: bus lock.
- `data_gnt_i` in 1: grant.
- `data_rvalid_i` in 1: response valid.
- `data_rdata_i` in 32: read data.
- `data_err_i` in 1: bus error, qualified by rvalid.
- `lspl_valid_o` out 1: result pulse.
- `lspl_output_o` out `pl_out_t`: result. Fields: wdata[31:0], err, rd, pc, rf_we.

## Operation
- **Request types** (amo_flag):
  - 0000: plain; a load when rf_we=1, a store when rf_we=0.
  - 0100: AMO read; a load that sets the lock.
  - 1000: AMO write; a store that releases the lock.
  - Any other amo_flag value is an error response.
- **Accept:** a request is accepted when `lsu_req_valid_i & lsu_rdy_o`. All request fields are registered on acceptance. `lsu_rdy_o = (state==IDLE)`.
- **data_type:** 00 word, 01 half, 10 byte, 11 reserved.
- **Immediate errors:** each of the following produces an error response without any bus transaction:
  - misalignment: word with addr[1:0]≠0, or half with addr[0]=1;
  - data_type 11;
  - AMO with data_type≠00;
  - illegal amo_flag.
- **Bus outputs:**
  - data_addr_o = {addr[31:2],2'b00}.
  - data_be_o: word 4'hF; half 4'b0011<<addr[1:0]; byte 4'b0001<<addr[1:0].
  - data_wdata_o: word as-is; half {2{wdata[15:0]}}; byte {4{wdata[7:0]}}.
- **Load result:** extract the addressed lane and sign-extend to 32 bits. Stores return wdata=0.
- **Result fields:** lspl_output_o.rd, .pc and .rf_we are copied from the registered request. err = data_err_i, or 1 for immediate errors.
- **States:**
  - IDLE → REQ on a legal accept.
  - IDLE → ERR on an accept that hits an immediate error.
  - REQ (data_req_o=1, outputs stable) → WAIT on data_gnt_i.
  - WAIT → RESP on data_rvalid_i; rdata and err are captured.
  - RESP: lspl_valid_o=1 for exactly one cycle, then → IDLE.
  - ERR: lspl_valid_o=1 with err=1 for one cycle, then → IDLE.
  - DRAIN: waits for data_rvalid_i, discards it, then → IDLE; lspl_valid_o stays 0.
- **Lock:**
  - data_lock_o sets in the cycle after a legal AMO-read accept.
  - It clears when the AMO-write RESP completes, or an AMO-read response returns err=1, or on flush.
  - Plain requests issued while the lock is held leave it unchanged.
- **Flush** (highest priority):
  - IDLE, ERR or RESP → IDLE; the pending pulse is suppressed.
  - REQ → IDLE; data_req_o drops next cycle. This is legal only when the request was not granted in the same cycle. If data_gnt_i=1 in the flush cycle → DRAIN.
  - WAIT → DRAIN, or IDLE if data_rvalid_i=1 in the same cycle.
  - A request presented in the flush cycle is not accepted.
- **Reset:** state IDLE. lsu_rdy_o=1 (combinational from IDLE). All other outputs are 0: data_req_o, data_we_o, data_be_o, data_addr_o, data_wdata_o, data_lock_o, lspl_valid_o and all lspl_output_o fields.

## Timing
- **Accept in cycle 0:** data_req_o is high in cycle 1. All bus outputs are registered.
- **Grant in cycle g ≥ 1:** data_req_o is low in cycle g+1.
- **rvalid in cycle r:** lspl_valid_o in cycle r+1. Minimum load-to-result latency is 3 cycles: accept at 0, gnt at 1, rvalid at 2, result at 3.
- **Immediate error:** lspl_valid_o in cycle 1, and lsu_rdy_o is high again in cycle 2.
- **Back-to-back:** lsu_rdy_o re-asserts the cycle after the RESP/ERR cycle. The next accept can happen in that cycle.
- **Throughput:** one outstanding bus transaction at most. data_rvalid_i is ignored in IDLE, REQ and RESP.
- **Reset mid-transaction:** asynchronous return to IDLE. The lock and all bus outputs drop immediately.

## Test plan
- **Word load:** accept addr 0x1000, rf_we=1, type 00; gnt at cycle 1; rvalid at cycle 2 with rdata 0xDEADBEEF → lspl_valid_o at cycle 3 with wdata 0xDEADBEEF, err=0; data_be_o=4'hF.
- **Byte load:** accept addr 0x1003, type 10; rdata 0x80FF_0000 → data_be_o=4'b1000; wdata 0xFFFFFF80.
- **Half store:** accept addr 0x2002, wdata 0x1234ABCD, rf_we=0 → data_we_o=1, data_be_o=4'b1100, data_wdata_o 0xABCDABCD; response wdata=0, rf_we=0.
- **Misaligned word:** accept addr 0x1001 → no data_req_o; lspl_valid_o at cycle 1 with err=1.
- **AMO pair:**
  - AMO read at 0x3000 returns 5 → data_lock_o high from cycle 1 through the write response.
  - AMO write with wdata 8 → data_we_o=1; lock low the cycle after the write RESP.
  - Repeat with data_err_i=1 on the read → lock clears and err=1.
- **Flush:**
  - Flush in WAIT → no lspl_valid_o; the late rvalid is drained; lsu_rdy_o returns the cycle after rvalid.
  - Flush in REQ without gnt → data_req_o low next cycle; no response.
